fmul_round_norm: RTL

- Downstream stage of the floating-point multiplier: consumes the raw product (sign, biased-exponent sum, full-width mantissa product, operand class) and produces a normalised, correctly rounded IEEE-754 result.
- Rounding is round-to-nearest-even. Subnormal results flush to zero.
- Two-stage valid/ready pipeline (normalise, then round/pack), so the multiplier core can be registered ahead of it.

---
 rtl/fmul_round_norm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fmul_round_norm.sv
// Round/normalise stage of the FP multiplier: two-stage valid/ready pipeline
// turning a raw mantissa product into a packed IEEE-754 result (RNE, FTZ).
module fmul_round_norm #(
  parameter  int N        = 32,
  localparam int EXP_LEN  = (N == 64) ? 11 : 8,
  localparam int FRAC_LEN = (N == 64) ? 52 : 23,
  localparam int BIAS     = (N == 64) ? 1023 : 127,
  localparam int PROD_W   = 2 * (FRAC_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_LEN+1:0]   in_exp,
  input  logic [PROD_W-1:0]    in_man,
  input  logic [1:0]           in_class,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic                 out_inx
);

  localparam int EW = EXP_LEN + 3;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_LEN) - 1);

  typedef enum logic [1:0] {
    CL_NORM = 2'd0,
    CL_ZERO = 2'd1,
    CL_INF  = 2'd2,
    CL_NAN  = 2'd3
  } class_e;

  // Stage 1 state
  logic                  r_s1_valid;
  logic                  r_s1_sign;
  class_e                r_s1_class;
  logic signed [EW-1:0]  r_s1_e;
  logic [FRAC_LEN-1:0]   r_s1_frac;
  logic                  r_s1_g;
  logic                  r_s1_s;

  // Stage 2 state
  logic                  r_s2_valid;
  logic [N-1:0]          r_out;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  r_inx;

  logic                  w_s1_adv;
  logic                  w_s2_adv;

  logic                  w_norm;
  logic [FRAC_LEN-1:0]   w_frac;
  logic                  w_g;
  logic                  w_s;
  logic signed [EW-1:0]  w_e;

  logic                  w_rnd;
  logic [FRAC_LEN:0]     w_sum;
  logic signed [EW-1:0]  w_e2;
  logic [N-1:0]          w_res;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_inx;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_adv;
  assign in_ready  = !r_s1_valid || w_s1_adv;

  assign out_valid = r_s2_valid;
  assign out       = r_out;
  assign out_ovf   = r_ovf;
  assign out_unf   = r_unf;
  assign out_inx   = r_inx;

  // Normalise: product lies in [1,4), so at most a one-bit shift.
  assign w_norm = in_man[PROD_W-1];
  assign w_frac = w_norm ? in_man[PROD_W-2 -: FRAC_LEN] : in_man[PROD_W-3 -: FRAC_LEN];
  assign w_g    = w_norm ? in_man[PROD_W-2-FRAC_LEN] : in_man[PROD_W-3-FRAC_LEN];
  assign w_s    = w_norm ? |in_man[PROD_W-3-FRAC_LEN:0] : |in_man[PROD_W-4-FRAC_LEN:0];
  assign w_e    = $signed({1'b0, in_exp}) - BIAS_S + $signed({{(EW-1){1'b0}}, w_norm});

  // Round to nearest even; a carry out leaves the fraction at zero.
  assign w_rnd = r_s1_g && (r_s1_s || r_s1_frac[0]);
  assign w_sum = {1'b0, r_s1_frac} + {{FRAC_LEN{1'b0}}, w_rnd};
  assign w_e2  = r_s1_e + $signed({{(EW-1){1'b0}}, w_sum[FRAC_LEN]});

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = 1'b0;
    unique case (r_s1_class)
      CL_ZERO: w_res = {r_s1_sign, {EXP_LEN{1'b0}}, {FRAC_LEN{1'b0}}};
      CL_INF:  w_res = {r_s1_sign, {EXP_LEN{1'b1}}, {FRAC_LEN{1'b0}}};
      CL_NAN:  w_res = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(FRAC_LEN-1){1'b0}}};
      default: begin
        if (w_e2 >= EMAX_S) begin
          w_res = {r_s1_sign, {EXP_LEN{1'b1}}, {FRAC_LEN{1'b0}}};
          w_ovf = 1'b1;
          w_inx = 1'b1;
        end else if (w_e2[EW-1] || (w_e2 == '0)) begin
          w_res = {r_s1_sign, {EXP_LEN{1'b0}}, {FRAC_LEN{1'b0}}};
          w_unf = 1'b1;
          w_inx = 1'b1;
        end else begin
          w_res = {r_s1_sign, w_e2[EXP_LEN-1:0], w_sum[FRAC_LEN-1:0]};
          w_inx = r_s1_g || r_s1_s;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_class <= CL_NORM;
      r_s1_e     <= '0;
      r_s1_frac  <= '0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= in_sign;
        r_s1_class <= class_e'(in_class);
        r_s1_e     <= w_e;
        r_s1_frac  <= w_frac;
        r_s1_g     <= w_g;
        r_s1_s     <= w_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_inx      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_res;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
        r_inx <= w_inx;
      end
    end
  end

endmodule
